pipe_skid_buffer: RTL and testbench
===================================

PIPE_SKID_BUFFER -- requirements
Module: pipe_skid_buffer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, which sets the payload width in bits.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port flush, input, 1 bit: synchronous discard of all buffered data.
REQ-005 The module SHALL have port in_valid, input, 1 bit: upstream offers in_data.
REQ-006 The module SHALL have port in_data, input, WIDTH bits: upstream payload.
REQ-007 The module SHALL have port in_ready, output, 1 bit: buffer can accept; taken directly from a flop, with no combinational path from out_ready.
REQ-008 The module SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-009 The module SHALL have port out_data, output, WIDTH bits: downstream payload, taken directly from a flop.
REQ-010 The module SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-011 The module SHALL have port count, output, 2 bits: occupancy, 0 to 2.

Function
REQ-012 A transfer SHALL occur on a port in a cycle only when both its valid and its ready are 1 at the rising edge.
REQ-013 The module SHALL hold two registers: a main register, which drives out_data, and a skid register.
REQ-014 The module SHALL implement three states, encoded in count: EMPTY=0, BUSY=1 (main full), FULL=2 (main and skid full).
REQ-015 The module SHALL drive out_valid = (count != 0) and in_ready = (count != 2).
REQ-016 EMPTY: on an input transfer, main SHALL load in_data and the state SHALL go to BUSY; otherwise the state SHALL hold.
REQ-017 BUSY with input transfer and output transfer: main SHALL load in_data and the state SHALL stay BUSY.
REQ-018 BUSY with input transfer and no output transfer: skid SHALL load in_data, main SHALL hold, and the state SHALL go to FULL.
REQ-019 BUSY with output transfer and no input transfer: the state SHALL go to EMPTY.
REQ-020 BUSY with neither transfer: the state SHALL hold.
REQ-021 FULL with output transfer: main SHALL load skid and the state SHALL go to BUSY; no input transfer is possible in FULL because in_ready=0.
REQ-022 FULL with no output transfer: the state SHALL hold.
REQ-023 Latency SHALL be 1 cycle: data accepted at edge N SHALL appear on out_data after edge N when the buffer was EMPTY, or after the same edge at which the older word leaves.
REQ-024 The module SHALL preserve ordering: words SHALL exit in acceptance order, with no loss and no duplication.
REQ-025 Stability: while out_valid=1 and out_ready=0, out_data and out_valid SHALL remain unchanged.
REQ-026 Throughput: with in_valid=1 and out_ready=1 continuously, the module SHALL sustain one word per cycle.
REQ-027 flush=1 SHALL force the state to EMPTY at the next edge, discard any word presented in that cycle, and leave the register contents don't-care.
REQ-028 Priority SHALL be reset > flush > normal operation.
REQ-029 out_data SHALL hold its last value while EMPTY; it is not cleared.

Reset
REQ-030 Reset SHALL be synchronous and active-high; when reset=1 at a rising edge of clk, the module SHALL take its reset state, regardless of any other input.
REQ-031 After reset, outputs SHALL be: count=0, out_valid=0, in_ready=1, out_data=0; the skid register SHALL be 0.
REQ-032 An input transfer presented in the same cycle as reset SHALL be discarded.
REQ-033 Reset asserted mid-operation, including in FULL, SHALL drop all buffered words, with no partial state retained.

Verification
REQ-034 Reset, then idle for 3 cycles -> count=0, out_valid=0, in_ready=1, out_data=0 on every cycle.
REQ-035 WIDTH=8; stream 0x01..0x10 with out_ready=1 throughout -> 16 words out in order, first word one cycle after acceptance, one word per cycle, count=1 steady.
REQ-036 Accept 0xA5, then 0x5A, with out_ready=0 -> count=2, in_ready=0, out_data=0xA5 held stable; raise out_ready -> 0xA5 then 0x5A, count goes 2,1,0.
REQ-037 Random in_valid/out_ready at 50% each over 1000 words -> scoreboard sees identical in-order sequence; in_ready is never 1 when count=2.
REQ-038 FULL with 0x11/0x22, flush=1 for one cycle with in_valid=1 and in_data=0x33 -> count=0 next cycle; 0x11, 0x22 and 0x33 are never output.
REQ-039 FULL, reset=1 for one cycle -> count=0, out_valid=0, out_data=0, in_ready=1 after the edge; the next accepted 0x44 is the first word output.

Source files
------------

// File: rtl/pipe_skid_buffer.sv
// -----------------------------------------------------------------------------
// pipe_skid_buffer
//   Two-entry pipeline register with a skid slot. It breaks the ready path
//   between two valid/ready stages: in_ready, out_valid and out_data all come
//   straight from flops, so nothing combinational runs from out_ready back to
//   in_ready. It sustains one word per cycle when both sides stream.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   reset      : synchronous, active-high; clears state and both data registers
//   flush      : synchronous discard of buffered words (register contents kept)
//   in_valid   : upstream offers in_data
//   in_data    : upstream payload, WIDTH bits
//   in_ready   : buffer can accept (registered)
//   out_valid  : out_data holds a word
//   out_data   : downstream payload (main register)
//   out_ready  : downstream accepts
//   count      : occupancy 0..2 (doubles as the state encoding)
// -----------------------------------------------------------------------------
module pipe_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_in_ready;
    logic             r_out_valid;

    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_main_from_in;
    logic             w_main_from_skid;
    logic             w_skid_from_in;

    assign w_in_xfer  = in_valid & r_in_ready;
    assign w_out_xfer = r_out_valid & out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_main_from_in   = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_from_in   = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_xfer) begin
                    w_main_from_in = 1'b1;
                    w_state_nxt    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_main_from_in = 1'b1;
                end else if (w_in_xfer) begin
                    // Downstream stalled: park the new word behind main.
                    w_skid_from_in = 1'b1;
                    w_state_nxt    = ST_FULL;
                end else if (w_out_xfer) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only the output side can move.
                if (w_out_xfer) begin
                    w_main_from_skid = 1'b1;
                    w_state_nxt      = ST_BUSY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            // Data registers are left as-is; their contents no longer matter.
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            // Handshake flags are precomputed from the next state so they
            // leave the block as plain flop outputs.
            r_in_ready  <= (w_state_nxt != ST_FULL);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            if (w_main_from_in)
                r_main <= in_data;
            else if (w_main_from_skid)
                r_main <= r_skid;
            if (w_skid_from_in)
                r_skid <= in_data;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;
    assign count     = r_state;

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_buffer
//   Directed and random stimulus for pipe_skid_buffer (WIDTH=8). A queue model
//   of the buffer contents is checked against the DUT on every falling edge;
//   directed sections add literal expectations at known points.
// -----------------------------------------------------------------------------
module tb_pipe_skid_buffer;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [1:0]       count;

    int n_checks = 0;
    int n_errors = 0;

    pipe_skid_buffer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: an ordered queue of at most 2 words
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_last;
    bit               m_known;
    bit               m_ox, m_ix;
    bit               chk_en = 0;
    int               n_acc = 0;
    int               n_out = 0;

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_last  = '0;
            m_known = 1;
        end else if (flush) begin
            q.delete();
            m_known = 0;
        end else begin
            m_ox = (q.size() != 0) && out_ready;
            m_ix = in_valid && (q.size() < 2);
            if (m_ox) begin
                m_last = q.pop_front();
                n_out++;
            end
            if (m_ix) begin
                q.push_back(in_data);
                n_acc++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("count", 32'(count), 32'(q.size()));
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
            if (q.size() != 0)
                chk("out_data", 32'(out_data), 32'(q[0]));
            else if (m_known)
                chk("out_data_held", 32'(out_data), 32'(m_last));
            if (count == 2'd2)
                chk("in_ready_when_full", 32'(in_ready), 32'd0);
        end
    end

    // Inputs change 1 time unit after the rising edge; checks here see the
    // post-edge outputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base_acc, base_out, cyc;
        reset = 1; flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
        tick(); tick();
        chk_en = 1;
        reset = 0;

        // Idle after reset
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_count", 32'(count), 32'd0);
            chk("idle_out_valid", 32'(out_valid), 32'd0);
            chk("idle_in_ready", 32'(in_ready), 32'd1);
            chk("idle_out_data", 32'(out_data), 32'h00);
        end

        // Streaming 0x01..0x10 at full rate
        out_ready = 1; in_valid = 1;
        for (int i = 1; i <= 16; i++) begin
            in_data = 8'(i);
            tick();
            chk("stream_data", 32'(out_data), 32'(i));
            chk("stream_count", 32'(count), 32'd1);
        end
        in_valid = 0;
        tick();
        chk("stream_drained", 32'(count), 32'd0);
        chk("stream_hold", 32'(out_data), 32'h10);

        // Back-pressure: fill to FULL, hold, then drain
        out_ready = 0; in_valid = 1; in_data = 8'hA5;
        tick();
        chk("bp_cnt1", 32'(count), 32'd1);
        in_data = 8'h5A;
        tick();
        chk("bp_cnt2", 32'(count), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_data", 32'(out_data), 32'hA5);
        in_data = 8'hEE;  // offered while full: must not be taken
        tick();
        in_valid = 0;
        tick();
        chk("bp_stable", 32'(out_data), 32'hA5);
        chk("bp_stable_cnt", 32'(count), 32'd2);
        out_ready = 1;
        tick();
        chk("bp_drain1", 32'(out_data), 32'h5A);
        chk("bp_drain1_cnt", 32'(count), 32'd1);
        tick();
        chk("bp_drain0_cnt", 32'(count), 32'd0);
        chk("bp_drain0_vld", 32'(out_valid), 32'd0);

        // Flush while FULL with an input offered
        out_ready = 0; in_valid = 1; in_data = 8'h11;
        tick();
        in_data = 8'h22;
        tick();
        chk("fl_full", 32'(count), 32'd2);
        flush = 1; in_data = 8'h33;
        tick();
        flush = 0; in_valid = 0;
        chk("fl_cnt", 32'(count), 32'd0);
        chk("fl_vld", 32'(out_valid), 32'd0);
        out_ready = 1;
        tick(); tick();
        chk("fl_no_out", 32'(out_valid), 32'd0);

        // Flush while BUSY with an input offered: that word is dropped too
        out_ready = 0; in_valid = 1; in_data = 8'h66;
        tick();
        flush = 1; in_data = 8'h77;
        tick();
        flush = 0; in_valid = 0;
        chk("flb_cnt", 32'(count), 32'd0);
        tick();
        chk("flb_no_out", 32'(out_valid), 32'd0);

        // Reset while FULL, with a word offered during reset
        in_valid = 1; in_data = 8'h11;
        tick();
        in_data = 8'h22;
        tick();
        chk("rst_full", 32'(count), 32'd2);
        reset = 1; in_data = 8'h99; out_ready = 1;
        tick();
        reset = 0; in_valid = 0; out_ready = 0;
        chk("rst_cnt", 32'(count), 32'd0);
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'h00);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1; in_data = 8'h44;
        tick();
        in_valid = 0;
        chk("rst_first", 32'(out_data), 32'h44);
        chk("rst_first_vld", 32'(out_valid), 32'd1);
        out_ready = 1;
        tick();

        // Random traffic, 1000 words
        base_acc = n_acc;
        base_out = n_out;
        cyc = 0;
        while ((n_acc - base_acc) < 1000 && cyc < 20000) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        in_valid = 0; out_ready = 1;
        for (int i = 0; i < 4; i++) tick();
        chk("rand_timeout", 32'(cyc < 20000), 32'd1);
        chk("rand_in_count", 32'(n_acc - base_acc), 32'd1000);
        chk("rand_out_count", 32'(n_out - base_out), 32'd1000);
        chk("rand_empty", 32'(count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
